// File: rtl/buzzer_alert_sched.sv
// rtl/buzzer_alert_sched.sv - fixed-priority three-requester buzzer scheduler with square-wave tone generation (optional BUZZ_PREEMPT_EN)
module buzzer_alert_sched #(
    parameter int TICK_DIV = 50000,
    parameter int ON_MS    = 100,
    parameter int OFF_MS   = 100,
    parameter int GAP_MS   = 300,
    parameter int PER0     = 6250,
    parameter int PER1     = 12500,
    parameter int PER2     = 25000,
    parameter int BEEPS0   = 3,
    parameter int BEEPS1   = 2,
    parameter int BEEPS2   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    output logic       pwm_wave,
    output logic [2:0] grant,
    output logic [2:0] done,
    output logic       busy,
    output logic [2:0] pending
);

    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

    localparam logic [31:0] ON_CYC  = 32'(ON_MS * TICK_DIV);
    localparam logic [31:0] OFF_CYC = 32'(OFF_MS * TICK_DIV);
    localparam logic [31:0] GAP_CYC = 32'(GAP_MS * TICK_DIV);

    state_t      state, state_nxt;
    logic [31:0] dur, dur_nxt;
    logic [31:0] phase, phase_nxt, phase_inc;
    logic [31:0] per_cur, half_cur;
    logic [3:0]  beeps, beeps_nxt;
    logic [1:0]  sel, sel_nxt, pick;
    logic        pwm_nxt;
    logic [2:0]  grant_nxt, done_nxt, pending_nxt;
    logic [2:0]  clr_bits, reset_bits;
    logic        preempt;

    function automatic logic [3:0] beeps_of(input logic [1:0] idx);
        case (idx)
            2'd0:    return 4'(BEEPS0);
            2'd1:    return 4'(BEEPS1);
            default: return 4'(BEEPS2);
        endcase
    endfunction

    // Tone period of the requester currently being served.
    always_comb begin
        case (sel)
            2'd0:    per_cur = 32'(PER0);
            2'd1:    per_cur = 32'(PER1);
            default: per_cur = 32'(PER2);
        endcase
        half_cur  = per_cur >> 1;
        phase_inc = (phase == per_cur - 32'd1) ? 32'd0 : phase + 32'd1;
    end

    // Lowest set pending index wins.
    always_comb begin
        pick = 2'd2;
        if (pending[1]) pick = 2'd1;
        if (pending[0]) pick = 2'd0;
    end

    // Abort request from a higher-priority pending bit (only when compiled in).
    always_comb begin
        preempt = 1'b0;
`ifdef BUZZ_PREEMPT_EN
        if (state == S_ON || state == S_OFF)
            preempt = (pending & (grant - 3'd1)) != 3'b000;
`endif
    end

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_nxt  = state;
        dur_nxt    = dur;
        phase_nxt  = phase;
        beeps_nxt  = beeps;
        sel_nxt    = sel;
        pwm_nxt    = 1'b0;
        grant_nxt  = grant;
        done_nxt   = 3'b000;
        clr_bits   = 3'b000;
        reset_bits = 3'b000;
        case (state)
            S_IDLE: begin
                grant_nxt = 3'b000;
                if (pending != 3'b000) begin
                    clr_bits  = 3'b001 << pick;
                    sel_nxt   = pick;
                    grant_nxt = 3'b001 << pick;
                    beeps_nxt = beeps_of(pick);
                    phase_nxt = 32'd0;
                    dur_nxt   = ON_CYC - 32'd1;
                    pwm_nxt   = 1'b1;
                    state_nxt = S_ON;
                end
            end
            S_ON: begin
                if (preempt) begin
                    reset_bits = grant;
                    grant_nxt  = 3'b000;
                    phase_nxt  = 32'd0;
                    dur_nxt    = 32'd0;
                    state_nxt  = S_IDLE;
                end else if (dur == 32'd0) begin
                    beeps_nxt = beeps - 4'd1;
                    phase_nxt = 32'd0;
                    if (beeps != 4'd1) begin
                        dur_nxt   = OFF_CYC - 32'd1;
                        state_nxt = S_OFF;
                    end else begin
                        done_nxt  = grant;
                        grant_nxt = 3'b000;
                        if (GAP_MS == 0) begin
                            dur_nxt   = 32'd0;
                            state_nxt = S_IDLE;
                        end else begin
                            dur_nxt   = GAP_CYC - 32'd1;
                            state_nxt = S_GAP;
                        end
                    end
                end else begin
                    dur_nxt   = dur - 32'd1;
                    phase_nxt = phase_inc;
                    pwm_nxt   = phase_inc < half_cur;
                end
            end
            S_OFF: begin
                if (preempt) begin
                    reset_bits = grant;
                    grant_nxt  = 3'b000;
                    dur_nxt    = 32'd0;
                    state_nxt  = S_IDLE;
                end else if (dur == 32'd0) begin
                    phase_nxt = 32'd0;
                    dur_nxt   = ON_CYC - 32'd1;
                    pwm_nxt   = 1'b1;
                    state_nxt = S_ON;
                end else begin
                    dur_nxt = dur - 32'd1;
                end
            end
            default: begin
                grant_nxt = 3'b000;
                if (dur == 32'd0) state_nxt = S_IDLE;
                else              dur_nxt   = dur - 32'd1;
            end
        endcase
        // A request arriving on the same edge its bit is consumed is re-queued.
        pending_nxt = (pending & ~clr_bits) | req | reset_bits;
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            dur      <= 32'd0;
            phase    <= 32'd0;
            beeps    <= 4'd0;
            sel      <= 2'd0;
            pwm_wave <= 1'b0;
            grant    <= 3'b000;
            done     <= 3'b000;
            pending  <= 3'b000;
        end else begin
            state    <= state_nxt;
            dur      <= dur_nxt;
            phase    <= phase_nxt;
            beeps    <= beeps_nxt;
            sel      <= sel_nxt;
            pwm_wave <= pwm_nxt;
            grant    <= grant_nxt;
            done     <= done_nxt;
            pending  <= pending_nxt;
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_buzzer_alert_sched.sv
// tb/tb_buzzer_alert_sched.sv - directed self-checking bench for buzzer_alert_sched
module tb_buzzer_alert_sched;

    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic [2:0] req_o;
    logic       pwm_wave, busy;
    logic [2:0] grant, done, pending;
    logic       pwm_o, busy_o;
    logic [2:0] grant_o, done_o, pending_o;

    int checks = 0;
    int errors = 0;

    buzzer_alert_sched #(
        .TICK_DIV(10), .ON_MS(2), .OFF_MS(1), .GAP_MS(1), .PER0(4), .BEEPS0(2)
    ) u_dut (
        .clk(clk), .rst(rst), .req(req), .pwm_wave(pwm_wave), .grant(grant),
        .done(done), .busy(busy), .pending(pending)
    );

    buzzer_alert_sched #(
        .TICK_DIV(10), .ON_MS(2), .OFF_MS(1), .GAP_MS(0), .PER0(4), .PER1(5), .BEEPS0(2)
    ) u_odd (
        .clk(clk), .rst(rst), .req(req_o), .pwm_wave(pwm_o), .grant(grant_o),
        .done(done_o), .busy(busy_o), .pending(pending_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, input logic [2:0] exp, input int bound, output int n);
        n = 0;
        while (done === 3'b000 && n < bound) begin
            step();
            n++;
        end
        chk(tag, {29'd0, done}, {29'd0, exp});
    endtask

    task automatic wait_grant(input logic [2:0] exp, input int bound, output int n);
        n = 0;
        while (grant !== exp && n < bound) begin
            step();
            n++;
        end
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < bound) begin
            step();
            n++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        logic ok;
        rst   = 1'b1;
        req   = 3'b000;
        req_o = 3'b000;
        step();
        step();
        chk("rst_pwm", {31'd0, pwm_wave}, 32'd0);
        chk("rst_grant", {29'd0, grant}, 32'd0);
        chk("rst_done", {29'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pending", {29'd0, pending}, 32'd0);
        rst = 1'b0;
        step();

        // Single alert on requester 0.
        req = 3'b001;
        step();
        req = 3'b000;
        chk("s1_pend_latch", {29'd0, pending}, 32'd1);
        chk("s1_grant_e0", {29'd0, grant}, 32'd0);
        step();
        chk("s1_grant_e1", {29'd0, grant}, 32'd1);
        chk("s1_busy", {31'd0, busy}, 32'd1);
        chk("s1_pend_clr", {29'd0, pending}, 32'd0);
        for (int c = 0; c < 20; c++) begin
            chk("s1_on1_pwm", {31'd0, pwm_wave}, {31'd0, (c % 4) < 2});
            step();
        end
        for (int c = 0; c < 10; c++) begin
            chk("s1_off_pwm", {31'd0, pwm_wave}, 32'd0);
            step();
        end
        chk("s1_off_grant", {29'd0, grant}, 32'd1);
        for (int c = 0; c < 20; c++) begin
            chk("s1_on2_pwm", {31'd0, pwm_wave}, {31'd0, (c % 4) < 2});
            step();
        end
        chk("s1_done", {29'd0, done}, 32'd1);
        chk("s1_gap_grant", {29'd0, grant}, 32'd0);
        chk("s1_gap_pwm", {31'd0, pwm_wave}, 32'd0);
        for (int c = 0; c < 10; c++) begin
            chk("s1_gap_busy", {31'd0, busy}, 32'd1);
            step();
        end
        chk("s1_idle_busy", {31'd0, busy}, 32'd0);
        chk("s1_idle_done", {29'd0, done}, 32'd0);

        // Simultaneous requests 1 and 2.
        req = 3'b110;
        step();
        req = 3'b000;
        step();
        chk("s2_grant1", {29'd0, grant}, 32'd2);
        ok = 1'b1;
        n  = 0;
        while (done === 3'b000 && n < 200) begin
            if (pending !== 3'b100 || grant !== 3'b010) ok = 1'b0;
            step();
            n++;
        end
        chk("s2_pend_hold", {31'd0, ok}, 32'd1);
        chk("s2_done1", {29'd0, done}, 32'd2);
        chk("s2_len1", 32'(n), 32'd50);
        wait_grant(3'b100, 50, n);
        chk("s2_gap_len", 32'(n), 32'd11);
        chk("s2_pend_clr", {29'd0, pending}, 32'd0);
        wait_done("s2_done2", 3'b100, 200, n);
        chk("s2_len2", 32'(n), 32'd20);
        wait_idle("s2_idle", 100);

        // Set-wins race on the grant edge.
        req = 3'b001;
        step();
        step();
        req = 3'b000;
        chk("s3_grant", {29'd0, grant}, 32'd1);
        chk("s3_requeue", {29'd0, pending}, 32'd1);
        wait_done("s3_done", 3'b001, 200, n);
        chk("s3_len", 32'(n), 32'd50);
        wait_grant(3'b001, 50, n);
        chk("s3_regrant_len", 32'(n), 32'd11);
        chk("s3_pend_clr", {29'd0, pending}, 32'd0);
        wait_idle("s3_idle", 200);

        // Reset in the middle of an ON period.
        req = 3'b011;
        step();
        req = 3'b000;
        step();
        chk("s4_pend", {29'd0, pending}, 32'd2);
        for (int c = 0; c < 5; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("s4_pwm", {31'd0, pwm_wave}, 32'd0);
        chk("s4_grant", {29'd0, grant}, 32'd0);
        chk("s4_pending", {29'd0, pending}, 32'd0);
        chk("s4_busy", {31'd0, busy}, 32'd0);
        ok = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (done !== 3'b000 || busy !== 1'b0) ok = 1'b0;
            step();
        end
        chk("s4_no_done", {31'd0, ok}, 32'd1);

        // Odd period and zero gap on the second instance.
        req_o = 3'b010;
        step();
        req_o = 3'b000;
        step();
        chk("s5_grant", {29'd0, grant_o}, 32'd2);
        for (int c = 0; c < 20; c++) begin
            chk("s5_on_pwm", {31'd0, pwm_o}, {31'd0, (c % 5) < 2});
            step();
        end
        for (int c = 0; c < 30; c++) begin
            if (c == 29) chk("s5_busy_last_on", {31'd0, busy_o}, 32'd1);
            step();
        end
        chk("s5_done", {29'd0, done_o}, 32'd2);
        chk("s5_busy_drop", {31'd0, busy_o}, 32'd0);
        step();
        chk("s5_done_clr", {29'd0, done_o}, 32'd0);

        // Higher-priority request arriving while requester 2 is in ON.
        req = 3'b100;
        step();
        req = 3'b000;
        step();
        chk("s6_grant2", {29'd0, grant}, 32'd4);
        step();
        step();
        step();
        req = 3'b001;
        step();
        req = 3'b000;
        chk("s6_pend_both", {29'd0, pending}, 32'd1);
        step();
`ifdef BUZZ_PREEMPT_EN
        chk("s6_abort_pwm", {31'd0, pwm_wave}, 32'd0);
        chk("s6_abort_done", {29'd0, done}, 32'd0);
        chk("s6_requeue2", {29'd0, pending}, 32'd5);
        step();
        chk("s6_grant0", {29'd0, grant}, 32'd1);
        chk("s6_pend2", {29'd0, pending}, 32'd4);
        chk("s6_no_done", {29'd0, done}, 32'd0);
        wait_done("s6_done0", 3'b001, 200, n);
        chk("s6_len0", 32'(n), 32'd50);
`else
        chk("s6_keep_grant", {29'd0, grant}, 32'd4);
        chk("s6_keep_pwm", {31'd0, pwm_wave}, 32'd1);
        wait_done("s6_done2", 3'b100, 200, n);
        chk("s6_len2", 32'(n), 32'd15);
        wait_grant(3'b001, 50, n);
        chk("s6_gap_len", 32'(n), 32'd11);
`endif
        wait_idle("s6_idle", 400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
